// File: rtl/round_key_sequencer_if.sv
// Round-key stream between the key sequencer (master) and the cipher round datapath (slave).
// A key transfers on any clock edge where rk_valid and rk_ready are both high; while
// rk_valid is high and rk_ready low, round_key, round_idx and last hold stable.
interface round_key_sequencer_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] round_key;
    logic [3:0]   round_idx;
    logic         last;

    modport master (
        output rk_valid,
        output round_key,
        output round_idx,
        output last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  round_key,
        input  round_idx,
        input  last,
        output rk_ready
    );
endinterface

// File: rtl/round_key_sequencer.sv
// Registers a flat AES expanded-key schedule on load and streams one round key per transfer,
// forward (0..Nr) or reverse (Nr..0). Optional RK_ZEROIZE_EN clears schedule/key on stream exit.
module round_key_sequencer #(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   decrypt,
    input  logic                   abort,
    input  logic [0:128*(Nr+1)-1]  words,
    output logic                   busy,
    output logic                   state_dbg,
    round_key_sequencer_if.master  rk
);

    localparam int         SW       = 128 * (Nr + 1);
    localparam logic [3:0] LAST_FWD = 4'(Nr);

`ifdef RK_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    if (N != 32 * Nk || Nr != Nk + 6 || Nr > 14) begin : g_cfg_check
        $error("round_key_sequencer: N, Nr and Nk do not describe an AES key size");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic [3:0]    idx_q, idx_d;
    logic [0:127]  key_q, key_d;
    logic [0:SW-1] sched_q;
    logic          cap, clr, adv, at_end;
    // Slot offset is round_idx*128; 11 bits covers every schedule up to Nr=14.
    logic [10:0]   off_d;

    assign at_end       = dir_q ? (idx_q == 4'd0) : (idx_q == LAST_FWD);
    assign rk.rk_valid  = (state_q == STREAM);
    assign rk.round_key = key_q;
    assign rk.round_idx = idx_q;
    assign rk.last      = (state_q == STREAM) && at_end;
    assign busy         = (state_q == STREAM);
    assign state_dbg    = state_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        key_d   = key_q;
        cap     = 1'b0;
        clr     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = STREAM;
                    dir_d   = decrypt;
                    idx_d   = decrypt ? LAST_FWD : 4'd0;
                    cap     = 1'b1;
                end
            end
            STREAM: begin
                // Abort wins over a transfer presented on the same edge.
                if (abort) begin
                    state_d = IDLE;
                    clr     = ZEROIZE;
                end else if (rk.rk_ready) begin
                    if (at_end) begin
                        state_d = IDLE;
                        clr     = ZEROIZE;
                    end else begin
                        idx_d = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                        adv   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        off_d = {idx_d, 7'd0};
        if (cap) begin
            key_d = words[off_d +: 128];
        end else if (adv) begin
            key_d = sched_q[off_d +: 128];
        end else if (clr) begin
            key_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            idx_q   <= 4'd0;
            key_q   <= '0;
            sched_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            if (cap) begin
                sched_q <= words;
            end else if (clr) begin
                sched_q <= '0;
            end
        end
    end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Consumes the full flat expanded-key bus produced by the combinational key-expansion stage.
- Registers the schedule on a load strobe.
- Streams one 128-bit round key per accepted transfer to the iterative cipher round datapath over a valid/ready handshake.
- Order is forward (round 0..Nr) for encryption and reverse (round Nr..0) for decryption.

Parameters:
- N, 128, cipher key length in bits (128/192/256).
- Nr, 10, number of rounds (10/12/14, matching N).
- Nk, 4, key length in 32-bit words (4/6/8, matching N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  start strobe; captures words and decrypt.
- decrypt  input  1  direction at load: 0 = forward, 1 = reverse.
- abort  input  1  synchronous cancel of an active stream.
- words  input  [0:128*(Nr+1)-1]  expanded schedule; round r key at bits [r*128 +: 128].
- busy  output  1  high while in STREAM.
- rk_valid  output  1  round_key/round_idx valid.
- rk_ready  input  1  consumer accepts the current key.
- round_key  output  [0:127]  current round key.
- round_idx  output  [3:0]  round number of round_key.
- last  output  1  high with rk_valid on the final key of the stream.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy=0, rk_valid=0, last=0, round_idx=0, round_key=0, stored schedule=0.
- States: IDLE, STREAM.
- IDLE:
  - load=1 captures words into the internal schedule register and latches decrypt.
  - round_idx set to 0 (forward) or Nr (reverse). Go to STREAM.
  - Latency is 1 cycle: load sampled at edge t gives rk_valid=1 and busy=1 after edge t.
- STREAM:
  - rk_valid=1. round_key = stored slot[round_idx], registered.
  - Transfer occurs on an edge with rk_valid & rk_ready.
  - No transfer: round_key, round_idx and last hold stable.
  - Transfer, not last: round_idx steps +1 (forward) or -1 (reverse). round_key updates on the same edge.
  - Transfer, last: go to IDLE. rk_valid, busy and last fall after that edge. round_idx keeps the final value.
  - last = rk_valid & (round_idx == Nr forward, or 0 reverse).
- round_idx never wraps. Forward stops at Nr, reverse stops at 0. Exactly Nr+1 transfers per stream.
- load while in STREAM is ignored. The schedule and stream are unaffected.
- abort=1 in STREAM: go to IDLE on the next edge. rk_valid, busy and last drop. abort has priority over a simultaneous transfer.
- abort in IDLE has no effect. abort=1 together with load in IDLE: load wins.
- words may change after load without effect until the next load.
- Reset asserted mid-stream returns immediately to the reset values. No partial stream resumes.
- Width rule: the slot select is round_idx*128. round_idx is 4 bits, sufficient for Nr up to 14.

Optional Feature:
- Macro: RK_ZEROIZE_EN.
- Defined: on the edge that leaves STREAM (final transfer or abort), the stored schedule and round_key are cleared to 0. round_key reads 0 in IDLE.
- Not defined: the schedule is retained. round_key holds the last presented key in IDLE until the next load.

Test Plan:
- Forward AES-128, rk_ready tied high. Key 000102030405060708090a0b0c0d0e0f through key expansion; load, decrypt=0 -> 11 consecutive valid cycles. idx 0 gives 000102030405060708090a0b0c0d0e0f. idx 10 gives 13111d7fe3944a17f307a78b4d2b30c5 with last=1. rk_valid=0 on the next cycle.
- Reverse, same key, decrypt=1 -> first key idx 10 = 13111d7fe3944a17f307a78b4d2b30c5. Final idx 0 = 000102030405060708090a0b0c0d0e0f with last=1. Exactly 11 transfers.
- Backpressure: rk_ready=0 for 3 cycles at idx 4 -> round_key/round_idx stable. On release, idx 5 follows. Total transfers still 11.
- Abort and reload: abort at idx 6; load asserted during STREAM earlier -> load ignored. After abort, rk_valid=0 next cycle. A new load restarts at idx 0.
- Reset mid-stream: rst_n=0 at idx 3 -> outputs 0 immediately, asynchronously. After release, no rk_valid until load.
- AES-256 (N=256, Nr=14, Nk=8), key 000102...1e1f, forward -> 15 transfers. idx 14 = 24fc79ccbf0979e9371ac23c6d68de36, last=1. With RK_ZEROIZE_EN, round_key=0 after the final transfer.
